// File: rtl/tage_update_ctrl.sv
// TAGE commit-side update sequencer: update FIFO plus a beat FSM driving the table write port.
// Define TAGE_USEFUL_RESET_EN to build the periodic useful-bit clearing sweep.
module tage_update_ctrl #(
  parameter int QUEUE_DEPTH         = 4,
  parameter int NUM_TABLES          = 4,
  parameter int INDEX_W             = 10,
  parameter int USEFUL_RESET_PERIOD = 262144
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              upd_valid,
  output logic                              upd_ready,
  input  logic                              upd_taken,
  input  logic [2:0]                        upd_provider,
  input  logic                              upd_provider_taken,
  input  logic                              upd_alt_taken,
  input  logic [(NUM_TABLES+1)*INDEX_W-1:0] upd_idx,
  output logic                              wr_valid,
  input  logic                              wr_ready,
  output logic [2:0]                        wr_table,
  output logic [INDEX_W-1:0]                wr_idx,
  output logic [2:0]                        wr_op,
  output logic                              sweep_active
);

  localparam int         IDX_ALL_W = (NUM_TABLES+1)*INDEX_W;
  localparam int         REC_W     = IDX_ALL_W + 6;
  localparam int         PTR_W     = $clog2(QUEUE_DEPTH);
  localparam logic [2:0] LP_NT     = 3'(NUM_TABLES);

  localparam logic [2:0] OP_CTR_INC = 3'd0;
  localparam logic [2:0] OP_CTR_DEC = 3'd1;
  localparam logic [2:0] OP_U_INC   = 3'd2;
  localparam logic [2:0] OP_U_DEC   = 3'd3;
  localparam logic [2:0] OP_ALLOC_T = 3'd4;
  localparam logic [2:0] OP_ALLOC_N = 3'd5;
`ifdef TAGE_USEFUL_RESET_EN
  localparam logic [2:0] OP_U_CLR   = 3'd6;
  localparam int         CNT_W      = (USEFUL_RESET_PERIOD > 1) ? $clog2(USEFUL_RESET_PERIOD) : 1;

  typedef enum logic [2:0] {S_IDLE, S_UPD_CTR, S_UPD_U, S_UPD_ALLOC, S_SWEEP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_UPD_CTR, S_UPD_U, S_UPD_ALLOC} state_t;
`endif

  logic [REC_W-1:0]     r_mem [QUEUE_DEPTH];
  logic [PTR_W:0]       r_wptr, r_rptr;
  logic [15:0]          r_lfsr;
  state_t               r_state;
  logic                 r_wr_valid;
  logic [2:0]           r_wr_table;
  logic [INDEX_W-1:0]   r_wr_idx;
  logic [2:0]           r_wr_op;
  logic [2:0]           r_alloc_tbl;
`ifdef TAGE_USEFUL_RESET_EN
  logic [CNT_W-1:0]     r_period;
  logic                 r_sweep_pending;
  logic                 r_sweep_active;
`endif

  logic                 w_full, w_empty, w_push, w_pop, w_hs;
  logic                 w_h_taken, w_h_pt, w_h_alt;
  logic [2:0]           w_h_prov;
  logic [IDX_ALL_W-1:0] w_h_idx;
  logic                 w_need_u, w_need_alloc;
  logic [2:0]           w_alloc_tbl;

  function automatic logic [INDEX_W-1:0] idx_of(input logic [IDX_ALL_W-1:0] idxs,
                                                input logic [2:0] tbl);
    idx_of = '0;
    for (int k = 0; k <= NUM_TABLES; k++)
      if (tbl == 3'(k)) idx_of = idxs[k*INDEX_W +: INDEX_W];
  endfunction

  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_push  = upd_valid && !w_full;
  assign w_hs    = r_wr_valid && wr_ready;

  // The head record stays in place until the last beat of its sequence is accepted.
  assign {w_h_taken, w_h_prov, w_h_pt, w_h_alt, w_h_idx} = r_mem[r_rptr[PTR_W-1:0]];

  assign w_need_u     = (w_h_prov != 3'd0) && (w_h_pt != w_h_alt);
  assign w_need_alloc = (w_h_pt != w_h_taken) && (w_h_prov < LP_NT);
  assign w_alloc_tbl  = (!r_lfsr[0] || (w_h_prov == LP_NT - 3'd1)) ? w_h_prov + 3'd1
                                                                   : w_h_prov + 3'd2;

  assign w_pop = w_hs && (((r_state == S_UPD_CTR) && !w_need_u && !w_need_alloc) ||
                          ((r_state == S_UPD_U) && !w_need_alloc) ||
                          (r_state == S_UPD_ALLOC));

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr[PTR_W-1:0]] <= {upd_taken, upd_provider, upd_provider_taken,
                                   upd_alt_taken, upd_idx};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_lfsr <= 16'hACE1;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wr_valid  <= 1'b0;
      r_wr_table  <= 3'd0;
      r_wr_idx    <= '0;
      r_wr_op     <= OP_CTR_INC;
      r_alloc_tbl <= 3'd0;
`ifdef TAGE_USEFUL_RESET_EN
      r_period        <= '0;
      r_sweep_pending <= 1'b0;
      r_sweep_active  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
`ifdef TAGE_USEFUL_RESET_EN
          if (r_sweep_pending) begin
            r_state         <= S_SWEEP;
            r_sweep_pending <= 1'b0;
            r_sweep_active  <= 1'b1;
            r_wr_valid      <= 1'b1;
            r_wr_table      <= 3'd7;
            r_wr_idx        <= '0;
            r_wr_op         <= OP_U_CLR;
          end else
`endif
          if (!w_empty) begin
            // Allocation target is fixed here so a stalled ALLOC beat cannot change.
            r_state     <= S_UPD_CTR;
            r_wr_valid  <= 1'b1;
            r_wr_table  <= w_h_prov;
            r_wr_idx    <= idx_of(w_h_idx, w_h_prov);
            r_wr_op     <= w_h_taken ? OP_CTR_INC : OP_CTR_DEC;
            r_alloc_tbl <= w_alloc_tbl;
          end
        end
        S_UPD_CTR, S_UPD_U: if (w_hs) begin
          if ((r_state == S_UPD_CTR) && w_need_u) begin
            r_state <= S_UPD_U;
            r_wr_op <= (w_h_pt == w_h_taken) ? OP_U_INC : OP_U_DEC;
          end else if (w_need_alloc) begin
            r_state    <= S_UPD_ALLOC;
            r_wr_table <= r_alloc_tbl;
            r_wr_idx   <= idx_of(w_h_idx, r_alloc_tbl);
            r_wr_op    <= w_h_taken ? OP_ALLOC_T : OP_ALLOC_N;
          end else begin
            r_state    <= S_IDLE;
            r_wr_valid <= 1'b0;
          end
        end
        S_UPD_ALLOC: if (w_hs) begin
          r_state    <= S_IDLE;
          r_wr_valid <= 1'b0;
        end
`ifdef TAGE_USEFUL_RESET_EN
        S_SWEEP: if (w_hs) begin
          if (r_wr_idx == '1) begin
            r_state        <= S_IDLE;
            r_wr_valid     <= 1'b0;
            r_sweep_active <= 1'b0;
          end else begin
            r_wr_idx <= r_wr_idx + 1'b1;
          end
        end
`endif
        default: begin
          r_state    <= S_IDLE;
          r_wr_valid <= 1'b0;
        end
      endcase
`ifdef TAGE_USEFUL_RESET_EN
      if (w_pop) begin
        if (r_period == CNT_W'(USEFUL_RESET_PERIOD - 1)) begin
          r_period        <= '0;
          r_sweep_pending <= 1'b1;
        end else begin
          r_period <= r_period + 1'b1;
        end
      end
`endif
    end
  end

  assign upd_ready = !w_full;
  assign wr_valid  = r_wr_valid;
  assign wr_table  = r_wr_table;
  assign wr_idx    = r_wr_idx;
  assign wr_op     = r_wr_op;
`ifdef TAGE_USEFUL_RESET_EN
  assign sweep_active = r_sweep_active;
`else
  assign sweep_active = 1'b0;
`endif

endmodule

// File: tb/tb_tage_update_ctrl.sv
// Directed bench for tage_update_ctrl; sweep section is built when TAGE_USEFUL_RESET_EN is defined.
module tb_tage_update_ctrl;
  localparam int NT = 4;
  localparam int IW = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              upd_valid = 1'b0;
  logic              upd_ready;
  logic              upd_taken = 1'b0;
  logic [2:0]        upd_provider = 3'd0;
  logic              upd_provider_taken = 1'b0;
  logic              upd_alt_taken = 1'b0;
  logic [(NT+1)*IW-1:0] upd_idx = '0;
  logic              wr_valid;
  logic              wr_ready = 1'b1;
  logic [2:0]        wr_table;
  logic [IW-1:0]     wr_idx;
  logic [2:0]        wr_op;
  logic              sweep_active;

  int errs = 0;
  int checks = 0;
  logic [15:0] m_lfsr;

  tage_update_ctrl #(.QUEUE_DEPTH(4), .NUM_TABLES(NT), .INDEX_W(IW),
                     .USEFUL_RESET_PERIOD(4)) dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_taken(upd_taken), .upd_provider(upd_provider),
    .upd_provider_taken(upd_provider_taken), .upd_alt_taken(upd_alt_taken),
    .upd_idx(upd_idx), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_table(wr_table), .wr_idx(wr_idx), .wr_op(wr_op),
    .sweep_active(sweep_active));

  always #5 clk = ~clk;

  // Reference LFSR, used only to line up the allocation choice.
  always @(posedge clk) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [(NT+1)*IW-1:0] mk_idx(input int base);
    logic [(NT+1)*IW-1:0] v;
    v = '0;
    for (int k = 0; k <= NT; k++) v[k*IW +: IW] = IW'(base*8 + k);
    return v;
  endfunction

  task automatic drive(input logic tk, input logic [2:0] prov, input logic pt,
                       input logic alt, input int base);
    upd_taken = tk; upd_provider = prov; upd_provider_taken = pt;
    upd_alt_taken = alt; upd_idx = mk_idx(base); upd_valid = 1'b1;
  endtask

  task automatic send(input logic tk, input logic [2:0] prov, input logic pt,
                      input logic alt, input int base);
    int n;
    drive(tk, prov, pt, alt, base);
    n = 0;
    while (!upd_ready && n < 50) begin tick(); n++; end
    chk("send_ready", upd_ready, 1);
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [2:0] et, input int ei, input logic [2:0] eo);
    int n;
    n = 0;
    while (!wr_valid && n < 20) begin tick(); n++; end
    chk({tag, "_valid"}, wr_valid, 1);
    chk({tag, "_table"}, wr_table, et);
    chk({tag, "_idx"},   wr_idx, ei);
    chk({tag, "_op"},    wr_op, eo);
    tick();
  endtask

  task automatic wait_lfsr_bit(input logic want);
    int n;
    n = 0;
    while (m_lfsr[1] !== want && n < 64) begin tick(); n++; end
    chk("lfsr_align", m_lfsr[1], want);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    upd_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  initial begin
    int j, k, cyc;
    logic acc;

    do_reset();
    chk("rst_upd_ready", upd_ready, 1);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_sweep_active", sweep_active, 0);

    // Single-beat update, latency and drain.
    drive(1, 3'd2, 1, 1, 1);
    tick();
    upd_valid = 1'b0;
    chk("lat_idle_cycle", wr_valid, 0);
    tick();
    chk("lat_valid", wr_valid, 1);
    chk("lat_table", wr_table, 2);
    chk("lat_idx", wr_idx, 10);
    chk("lat_op", wr_op, 0);
    tick();
    chk("lat_done_valid", wr_valid, 0);
    tick();
    chk("lat_fifo_empty", wr_valid, 0);
    chk("lat_ready", upd_ready, 1);

    // Provider 1 mispredict with lfsr[0]=1: skip one table.
    wait_lfsr_bit(1'b1);
    send(0, 3'd1, 1, 0, 2);
    beat("p1_ctr", 3'd1, 17, 3'd1);
    beat("p1_u", 3'd1, 17, 3'd3);
    beat("p1_alloc", 3'd3, 19, 3'd5);
    chk("p1_end", wr_valid, 0);

    // Provider NUM_TABLES mispredict: no allocation.
    send(0, 3'd4, 1, 0, 3);
    beat("p4_ctr", 3'd4, 28, 3'd1);
    beat("p4_u", 3'd4, 28, 3'd3);
    chk("p4_no_alloc", wr_valid, 0);

    // Base provider mispredict with lfsr[0]=0: allocate in table 1.
    wait_lfsr_bit(1'b0);
    send(1, 3'd0, 0, 1, 4);
    beat("p0_ctr", 3'd0, 32, 3'd0);
    beat("p0_alloc", 3'd1, 33, 3'd4);
    chk("p0_end", wr_valid, 0);

    // Provider NUM_TABLES-1 always allocates into the next table.
    wait_lfsr_bit(1'b1);
    send(1, 3'd3, 0, 0, 5);
    beat("p3_ctr", 3'd3, 43, 3'd0);
    beat("p3_alloc", 3'd4, 44, 3'd4);

    // Correct provider differing from alt: useful increment.
    send(1, 3'd2, 1, 0, 6);
    beat("uinc_ctr", 3'd2, 50, 3'd0);
    beat("uinc_u", 3'd2, 50, 3'd2);
    chk("uinc_end", wr_valid, 0);

    // Back-pressure: fill the FIFO while the port is stalled.
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'd2, 1, 1, 10 + i);
      chk("fill_ready", upd_ready, 1);
      tick();
    end
    drive(1, 3'd2, 1, 1, 14);
    chk("full_ready_low", upd_ready, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", wr_valid, 1);
      chk("stall_table", wr_table, 2);
      chk("stall_idx", wr_idx, 82);
      chk("stall_op", wr_op, 0);
      tick();
    end
    wr_ready = 1'b1;
    chk("full_pop_ready_low", upd_ready, 0);
    j = 0; k = 4; cyc = 0;
    while (j < 6 && cyc < 100) begin
      acc = upd_valid && upd_ready;
      if (wr_valid) begin
        chk("drain_table", wr_table, 2);
        chk("drain_idx", wr_idx, (10 + j) * 8 + 2);
        chk("drain_op", wr_op, 0);
        j++;
      end
      tick();
      cyc++;
      if (acc) begin
        k++;
        if (k < 6) drive(1, 3'd2, 1, 1, 10 + k);
        else upd_valid = 1'b0;
      end
    end
    upd_valid = 1'b0;
    chk("drain_count", j, 6);
    tick();
    chk("drain_end", wr_valid, 0);

    // Reset in the middle of a sequence with another entry queued.
    drive(0, 3'd1, 1, 0, 7);
    tick();
    drive(1, 3'd2, 1, 1, 8);
    tick();
    upd_valid = 1'b0;
    cyc = 0;
    while (!(wr_valid && wr_op == 3'd3) && cyc < 20) begin tick(); cyc++; end
    chk("mid_in_u", wr_op, 3);
    rst = 1'b0;
    tick();
    chk("mid_rst_valid", wr_valid, 0);
    chk("mid_rst_ready", upd_ready, 1);
    rst = 1'b1;
    tick(); tick(); tick();
    chk("mid_rst_empty", wr_valid, 0);

    // Four completed updates, then a fifth queued right after the fourth.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(1, 3'd2, 1, 1, 20 + i);
      beat("pre_sweep", 3'd2, (20 + i) * 8 + 2, 3'd0);
    end
    drive(1, 3'd2, 1, 1, 24);
    tick();
    upd_valid = 1'b0;
`ifdef TAGE_USEFUL_RESET_EN
    cyc = 0;
    while (!wr_valid && cyc < 10) begin tick(); cyc++; end
    for (int i = 0; i < 1024; i++) begin
      chk("sweep_active", sweep_active, 1);
      chk("sweep_table", wr_table, 7);
      chk("sweep_idx", wr_idx, i);
      chk("sweep_op", wr_op, 6);
      tick();
    end
    chk("sweep_done", sweep_active, 0);
`else
    chk("no_sweep_active", sweep_active, 0);
`endif
    beat("post_sweep", 3'd2, 194, 3'd0);
    chk("post_sweep_end", wr_valid, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/tage_update_ctrl.md
# tage_update_ctrl

Commit-side update sequencer for the TAGE branch predictor (history lengths 10/20/40/80). Buffers committed-branch update records in a small FIFO and turns each one into a sequence of single-beat table operations: counter train, useful-bit train, and allocation on mispredict. It also runs the periodic useful-bit clearing sweep. It sits between the commit stage and the TAGE table write port, which lookups own with priority.

## Interface
Parameters:
- QUEUE_DEPTH, 4: update FIFO entries (power of two, ≥2)
- NUM_TABLES, 4: tagged tables; table 0 is the bimodal base
- INDEX_W, 10: table index width
- USEFUL_RESET_PERIOD, 262144: completed updates between useful-bit sweeps

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- upd_valid  in  1  committed branch update offered
- upd_ready  out  1  FIFO can accept; equals !full
- upd_taken  in  1  resolved direction
- upd_provider  in  3  providing table, 0 = base, 1..NUM_TABLES = tagged
- upd_provider_taken  in  1  provider's prediction
- upd_alt_taken  in  1  alternate prediction
- upd_idx  in  (NUM_TABLES+1)*INDEX_W  per-table index, table k at bits [k*INDEX_W +: INDEX_W]
- wr_valid  out  1  table operation presented
- wr_ready  in  1  table port accepts; low whenever a lookup uses the port
- wr_table  out  3  target table; 7 = all tagged tables
- wr_idx  out  INDEX_W  target index
- wr_op  out  3  0 CTR_INC, 1 CTR_DEC, 2 U_INC, 3 U_DEC, 4 ALLOC_T, 5 ALLOC_N, 6 U_CLR
- sweep_active  out  1  high while in SWEEP

## Operation
- FIFO: enqueue on upd_valid & upd_ready. No bypass. When full, upd_ready is low even in a cycle that pops.
- FSM states: IDLE, UPD_CTR, UPD_U, UPD_ALLOC, SWEEP. Each non-IDLE state presents one beat and advances only on wr_valid & wr_ready.
- IDLE: if sweep_pending, go to SWEEP. Otherwise, if the FIFO is non-empty, go to UPD_CTR.
- UPD_CTR: table = upd_provider, idx = provider's index, op = taken ? CTR_INC : CTR_DEC.
- UPD_U: entered only if provider ≠ 0 and provider_taken ≠ alt_taken. op = U_INC if provider_taken == taken, else U_DEC.
- UPD_ALLOC: entered only if provider_taken ≠ taken and provider < NUM_TABLES.
  - Target = provider+1 if lfsr[0]==0 or provider == NUM_TABLES-1; otherwise provider+2.
  - op = taken ? ALLOC_T : ALLOC_N.
- Skipped states fall through combinationally. The FIFO head pops on the handshake of the entry's last beat, then the FSM returns to IDLE.
- LFSR: 16-bit, x^16+x^14+x^13+x^11+1, seed 16'hACE1, advances every cycle.
- Period counter:
  - Increments per popped entry.
  - On reaching USEFUL_RESET_PERIOD-1 with a pop, it wraps to 0 and sets sweep_pending.
- SWEEP:
  - Issues U_CLR, wr_table=7, wr_idx 0..2^INDEX_W-1 ascending, one per handshake.
  - Clears sweep_pending on entry; returns to IDLE after the handshake at idx all-ones.
  - The FIFO keeps accepting until full.

## Timing
- Reset values:
  - upd_ready=1, wr_valid=0, sweep_active=0.
  - FSM=IDLE, FIFO empty, counters 0, sweep_pending=0, lfsr=16'hACE1.
- Latency: entry accepted at edge t into an idle, empty controller → wr_valid first high in cycle t+2.
- While wr_valid=1 and wr_ready=0, wr_table/wr_idx/wr_op hold stable. wr_valid never drops without a handshake.
- Back-to-back beats: one per cycle while wr_ready=1. A 3-beat update occupies 3 cycles plus 1 IDLE cycle.
- Sweep runs 2^INDEX_W handshakes (1024 at default). It starts only from IDLE, never mid-update.
- Reset mid-update or mid-sweep: all state returns to reset values next edge; the partial sequence is abandoned.

## Configuration
- TAGE_USEFUL_RESET_EN defined: period counter, sweep_pending and SWEEP state present as above.
- Not defined: none of these exist; U_CLR is never issued; sweep_active is tied 0.

## Test plan
- Provider 2, provider_taken=1, alt=1, taken=1, wr_ready=1 → single beat (2, idx2, CTR_INC) at t+2; FIFO empty at t+3.
- Provider 1, provider_taken=1, alt=0, taken=0, lfsr[0]=1 → beats (1, CTR_DEC), (1, U_DEC), (3, ALLOC_N).
- Provider 4 mispredict → CTR and U beats only, no ALLOC. Provider 0 mispredict → (0, CTR), then ALLOC into table 1 or 2.
- 6 updates back-to-back with wr_ready=0 → upd_ready low after 4 accepted. Release wr_ready → all drain in order, beats stable while stalled.
- USEFUL_RESET_PERIOD=4, 4 updates → SWEEP issues 1024 U_CLR beats idx 0..1023, sweep_active high throughout; a 5th update queued during the sweep executes after it.
- Deassert rst during UPD_U with a non-empty FIFO → next cycle wr_valid=0, upd_ready=1, FIFO empty.
